pc_unit: RTL and testbench

- Parametrised next-generation program counter for the pipelined MIPS core; sits at the head of the IF stage.
- Selects the next fetch address from sequential, branch/jump redirect, exception entry or ERET return.
- Holds a redirect that arrives while IF is stalled until the stall releases.
- Flags fetch-address exceptions (misaligned or outside the text segment) with an ExcCode.

---
 rtl/pc_unit.sv | 106 ++++++++++
 tb/tb_pc_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter for the IF stage: sequential, redirect, exception and ERET sources,
// with a one-entry buffer for redirects that arrive during a stall. Optional macro: PC_UNIT_FETCH_CNT_EN.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] TEXT_LO   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] TEXT_HI   = WIDTH'(32'h0000_4ffc),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
    parameter logic [4:0]       ADEL_CODE = 5'd4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             redir_pending,
    output logic [4:0]       exc_code,
    output logic [31:0]      fetch_cnt
);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             trap;

    assign trap = exc_req | eret_req;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: traps and any unstalled edge drain the buffer
    always_comb begin
        state_d = state_q;
        if (trap)             state_d = IDLE;
        else if (stall)       state_d = redir_valid ? PEND : state_q;
        else                  state_d = IDLE;
    end

    // Next pc and buffered target in priority order
    always_comb begin
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        if (exc_req) begin
            pc_d = EXC_VEC;
        end else if (eret_req) begin
            pc_d = epc;
        end else if (stall) begin
            if (redir_valid) pend_target_d = redir_target;
        end else if (redir_valid) begin
            pc_d = redir_target;
        end else if (state_q == PEND) begin
            pc_d = pend_target_q;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VEC;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc            = pc_q;
    assign pc_plus4      = pc_q + WIDTH'(4);
    assign redir_pending = (state_q == PEND);
    assign exc_code      = ((pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI))
                           ? ADEL_CODE : 5'd0;

`ifdef PC_UNIT_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        pc_we;

    // pc is written on every edge except a stall hold
    assign pc_we = trap | ~stall;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (pc_we) fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fetch_cnt_q <= '0;
        else       fetch_cnt_q <= fetch_cnt_d;
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    assign fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, reset/counter sequences,
// and random stimulus against a queue-based reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redir_valid, exc_req, eret_req;
    logic [31:0] redir_target, epc;
    logic [31:0] pc, pc_plus4, fetch_cnt;
    logic        redir_pending;
    logic [4:0]  exc_code;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
        .redir_target(redir_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .pc(pc), .pc_plus4(pc_plus4), .redir_pending(redir_pending),
        .exc_code(exc_code), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_buf[$];
    logic [31:0] m_cnt;

    function automatic logic [4:0] m_exc(input logic [31:0] a);
        return ((a % 4) != 0 || a < 32'h3000 || a > 32'h4ffc) ? 5'd4 : 5'd0;
    endfunction

    function automatic logic [31:0] m_cnt_view();
`ifdef PC_UNIT_FETCH_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, ".pending"}, 32'(redir_pending), 32'(m_buf.size() != 0));
        chk({tag, ".exc_code"}, 32'(exc_code), 32'(m_exc(m_pc)));
        chk({tag, ".fetch_cnt"}, fetch_cnt, m_cnt_view());
    endtask

    task automatic m_reset();
        m_pc = 32'h3000;
        m_buf.delete();
        m_cnt = 0;
    endtask

    // Apply one cycle at a negedge; model steps with the edge; check at next negedge
    task automatic cycle(input bit st, input bit rv, input logic [31:0] tg,
                         input bit ex, input bit er, input logic [31:0] ep);
        stall = st; redir_valid = rv; redir_target = tg;
        exc_req = ex; eret_req = er; epc = ep;
        if (ex) begin
            m_pc = 32'h4180; m_buf.delete();
        end else if (er) begin
            m_pc = ep; m_buf.delete();
        end else if (st) begin
            if (rv) begin m_buf.delete(); m_buf.push_back(tg); end
        end else begin
            if (rv)                  m_pc = tg;
            else if (m_buf.size())   m_pc = m_buf.pop_front();
            else                     m_pc = m_pc + 32'd4;
            m_buf.delete();
        end
        if (ex || er || !st) m_cnt = m_cnt + 32'd1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; redir_valid = 0; redir_target = 0;
        exc_req = 0; eret_req = 0; epc = 0;
    endtask

    // Reset pulse starting between edges; checked immediately, released at next negedge
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk({tag, ".async_pc"}, pc, 32'h3000);
        chk({tag, ".async_pend"}, 32'(redir_pending), 32'd0);
        chk({tag, ".async_exc"}, 32'(exc_code), 32'd0);
        chk({tag, ".async_cnt"}, fetch_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          st, rv, ex, er;
        logic [31:0] tg, ep;
        logic [31:0] exp_pc;
        bit          exp_pend;
        logic [4:0]  exp_exc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit st, bit rv, logic [31:0] tg, bit ex, bit er,
                                logic [31:0] ep, logic [31:0] xp, bit xpend, logic [4:0] xexc);
        vec_t v;
        v.st = st; v.rv = rv; v.tg = tg; v.ex = ex; v.er = er; v.ep = ep;
        v.exp_pc = xp; v.exp_pend = xpend; v.exp_exc = xexc;
        return v;
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        m_reset();
        #1;
        chk("reset.pc", pc, 32'h3000);
        chk("reset.exc", 32'(exc_code), 32'd0);
        chk("reset.pend", 32'(redir_pending), 32'd0);
        chk("reset.cnt", fetch_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Three sequential edges after release
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            chk("seq.pc", pc, 32'h3000 + 32'(4 * i));
        end

        //           st rv target        ex er epc           exp_pc        pend exc
        vecs.push_back(mk(0, 1, 32'h3100, 0, 0, 0,            32'h3100,     0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,            32'h3104,     0, 0));
        vecs.push_back(mk(0, 1, 32'h3010, 0, 0, 0,            32'h3010,     0, 0));
        vecs.push_back(mk(1, 1, 32'h3200, 0, 0, 0,            32'h3010,     1, 0));
        vecs.push_back(mk(1, 1, 32'h3300, 0, 0, 0,            32'h3010,     1, 0));
        vecs.push_back(mk(1, 0, 0,        0, 0, 0,            32'h3010,     1, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,            32'h3300,     0, 0));
        vecs.push_back(mk(1, 1, 32'h3400, 0, 0, 0,            32'h3300,     1, 0));
        vecs.push_back(mk(1, 1, 32'h3500, 1, 1, 32'h3050,     32'h4180,     0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 1, 32'h3050,     32'h3050,     0, 0));
        vecs.push_back(mk(0, 1, 32'h3002, 0, 0, 0,            32'h3002,     0, 4));
        vecs.push_back(mk(0, 1, 32'h2ffc, 0, 0, 0,            32'h2ffc,     0, 4));
        vecs.push_back(mk(0, 1, 32'h5000, 0, 0, 0,            32'h5000,     0, 4));
        vecs.push_back(mk(0, 1, 32'h4ffc, 0, 0, 0,            32'h4ffc,     0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,            32'h5000,     0, 4));
        vecs.push_back(mk(1, 1, 32'h3600, 0, 0, 0,            32'h5000,     1, 4));
        vecs.push_back(mk(0, 1, 32'h3700, 0, 0, 0,            32'h3700,     0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,            32'h3704,     0, 0));
        vecs.push_back(mk(0, 1, 32'hfffffffc, 0, 0, 0,        32'hfffffffc, 0, 4));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,            32'h0,        0, 4));

        foreach (vecs[i]) begin
            cycle(vecs[i].st, vecs[i].rv, vecs[i].tg, vecs[i].ex, vecs[i].er, vecs[i].ep);
            chk($sformatf("vec%0d.pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d.pend", i), 32'(redir_pending), 32'(vecs[i].exp_pend));
            chk($sformatf("vec%0d.exc", i), 32'(exc_code), 32'(vecs[i].exp_exc));
            chk($sformatf("vec%0d.cnt", i), fetch_cnt, m_cnt_view());
        end

        // Mid-operation reset discards a buffered redirect
        cycle(1, 1, 32'h3800, 0, 0, 0);
        chk("midrst.pend_before", 32'(redir_pending), 32'd1);
        idle_inputs();
        reset_pulse("midrst");
        cycle(0, 0, 0, 0, 0, 0);
        chk("midrst.resume_pc", pc, 32'h3004);
        chk("midrst.pend_after", 32'(redir_pending), 32'd0);

        // Counter: 5 sequential edges then 2 stall-hold edges
        reset_pulse("cnt");
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 0, 0);
`ifdef PC_UNIT_FETCH_CNT_EN
        chk("cnt.five", fetch_cnt, 32'd5);
`else
        chk("cnt.zero", fetch_cnt, 32'd0);
`endif
        chk("cnt.pc_held", pc, 32'h3014);

        // Random stimulus against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] tg;
            logic [31:0] ep;
            int          r;
            r  = $urandom_range(0, 99);
            tg = 32'h3000 + 32'($urandom_range(0, 32'h2100));
            if ($urandom_range(0, 3) == 0) tg = $urandom;
            ep = 32'h3000 + 32'(4 * $urandom_range(0, 32'h7ff));
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, tg,
                  r < 4, (r >= 4 && r < 9) || r == 0, ep);
            chk_all($sformatf("rnd%0d", n));
        end

        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
